// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART TX FIFO among N byte-capture requesters.
// Each granted byte is sent as a 6-character line: channel digit, ':', two hex digits, CR, LF.
module uart_tx_sched #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] data,
  output logic [N-1:0]   grant,
  input  logic           uart_full,
  output logic           wr_uart,
  output logic [7:0]     w_data,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_CH = IW'(N - 1);
  localparam logic [2:0]    LAST_IDX = 3'd5;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [IW-1:0] last;
  logic [IW-1:0] chan;
  logic [7:0]  cap;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic [7:0]    pick_data;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  function automatic logic [7:0] line_byte(input logic [2:0]    i,
                                           input logic [IW-1:0] ch,
                                           input logic [7:0]    b);
    logic [7:0] r;
    case (i)
      3'd0:    r = 8'h30 + {{(8-IW){1'b0}}, ch};
      3'd1:    r = 8'h3A;
      3'd2:    r = hex_char(b[7:4]);
      3'd3:    r = hex_char(b[3:0]);
      3'd4:    r = 8'h0D;
      default: r = 8'h0A;
    endcase
    return r;
  endfunction

  // Search starts one past the last-served channel so every requester gets a turn.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    found     = 1'b0;
    pick      = '0;
    cand      = last;
    pick_data = '0;
    for (int o = 0; o < N; o++) begin
      cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (pick == IW'(i)) pick_data = data[8*i +: 8];
    end
  end

  // The FIFO handshake is the one combinational path: a full flag cancels the write at once.
  assign wr_uart = (state == SEND) && !uart_full;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      last   <= LAST_CH;
      chan   <= '0;
      cap    <= '0;
      grant  <= '0;
      w_data <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          grant <= '0;
          if (found) begin
            chan   <= pick;
            cap    <= pick_data;
            last   <= pick;
            grant  <= {{(N-1){1'b0}}, 1'b1} << pick;
            idx    <= '0;
            w_data <= line_byte(3'd0, pick, pick_data);
            busy   <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          grant <= '0;
          // A stalled cycle leaves idx and w_data untouched, so the byte is simply retried.
          if (wr_uart) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx    <= idx + 3'd1;
              w_data <= line_byte(idx + 3'd1, chan, cap);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: line format, round-robin order, backpressure and reset.
module tb_uart_tx_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] data = '0;
  logic           uart_full = 1'b0;
  logic [N-1:0]   grant;
  logic           wr_uart;
  logic [7:0]     w_data;
  logic           busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_grant_cyc = 0;
  int w0 = 0;

  uart_tx_sched #(.N(N)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .data(data),
    .grant(grant),
    .uart_full(uart_full),
    .wr_uart(wr_uart),
    .w_data(w_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_uart) wr_count <= wr_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(negedge clk);
  endtask

  // Waits (bounded) for a grant, checks it is the expected channel and, if gap>0, its spacing.
  task automatic wait_grant(input int ch, input int gap);
    int n;
    n = 0;
    tick;
    while (grant == '0 && n < 20) begin
      tick;
      n++;
    end
    check("grant", 32'(grant), 32'(1) << ch);
    if (gap != 0) check("grant_gap", cyc - last_grant_cyc, gap);
    last_grant_cyc = cyc;
  endtask

  // Called on the grant cycle; checks the six bytes and the idle cycle that follows.
  task automatic expect_line(input int ch, input logic [47:0] line, input bit drop,
                             input bit mutate, input logic [7:0] nd);
    int start;
    start = wr_count;
    if (drop) req[ch] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        tick;
        check("grant_low", 32'(grant), 0);
      end
      check("busy", 32'(busy), 1);
      check("wr_uart", 32'(wr_uart), 1);
      check("w_data", 32'(w_data), 32'(line[47-8*i -: 8]));
      if (i == 1 && mutate) data[8*ch +: 8] = nd;
    end
    tick;
    check("idle_busy", 32'(busy), 0);
    check("idle_wr", 32'(wr_uart), 0);
    check("idle_hold", 32'(w_data), 32'h0A);
    check("write_count", wr_count - start, 6);
  endtask

  initial begin
    // Reset state
    tick;
    tick;
    check("rst_grant", 32'(grant), 0);
    check("rst_wr", 32'(wr_uart), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wdata", 32'(w_data), 0);

    // Single request, first grant one cycle after release
    data[7:0] = 8'h5A;
    req = 4'b0001;
    reset = 1'b1;
    last_grant_cyc = cyc;
    wait_grant(0, 1);
    expect_line(0, 48'h30_3A_35_41_0D_0A, 1'b1, 1'b0, 8'h00);

    // Round robin from a fresh reset, ch1 data changed after its grant
    reset = 1'b0;
    tick;
    data = {8'hC3, 8'h9B, 8'h01, 8'hF0};
    req = 4'b1111;
    reset = 1'b1;
    last_grant_cyc = cyc;
    wait_grant(0, 1);
    expect_line(0, 48'h30_3A_46_30_0D_0A, 1'b1, 1'b0, 8'h00);
    wait_grant(1, 7);
    expect_line(1, 48'h31_3A_30_31_0D_0A, 1'b1, 1'b1, 8'hEE);
    wait_grant(2, 7);
    expect_line(2, 48'h32_3A_39_42_0D_0A, 1'b1, 1'b0, 8'h00);
    wait_grant(3, 7);
    expect_line(3, 48'h33_3A_43_33_0D_0A, 1'b1, 1'b0, 8'h00);

    // Pointer wraps past 3: ch0 before ch1
    data[7:0] = 8'h12;
    data[15:8] = 8'h34;
    req = 4'b0011;
    wait_grant(0, 7);
    expect_line(0, 48'h30_3A_31_32_0D_0A, 1'b1, 1'b0, 8'h00);
    wait_grant(1, 7);
    expect_line(1, 48'h31_3A_33_34_0D_0A, 1'b1, 1'b0, 8'h00);

    // Backpressure at idx=2 on a ch3 line (0x7E)
    data[31:24] = 8'h7E;
    req = 4'b1000;
    wait_grant(3, 7);
    w0 = wr_count;
    req = 4'b0000;
    check("bp_b0", 32'(w_data), 32'h33);
    tick;
    check("bp_b1", 32'(w_data), 32'h3A);
    tick;
    check("bp_b2", 32'(w_data), 32'h37);
    check("bp_wr_pre", 32'(wr_uart), 1);
    uart_full = 1'b1;
    #1;
    check("bp_wr_cut", 32'(wr_uart), 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_stall_wr", 32'(wr_uart), 0);
      check("bp_stall_data", 32'(w_data), 32'h37);
      check("bp_stall_busy", 32'(busy), 1);
    end
    uart_full = 1'b0;
    #1;
    check("bp_wr_resume", 32'(wr_uart), 1);
    tick;
    check("bp_b3", 32'(w_data), 32'h45);
    tick;
    check("bp_b4", 32'(w_data), 32'h0D);
    tick;
    check("bp_b5", 32'(w_data), 32'h0A);
    check("bp_b5_wr", 32'(wr_uart), 1);
    tick;
    check("bp_done_busy", 32'(busy), 0);
    check("bp_write_count", wr_count - w0, 6);

    // Reset in the middle of a ch2 line, then ch0 has priority again
    data[23:16] = 8'h44;
    req = 4'b0100;
    wait_grant(2, 0);
    req = 4'b0000;
    tick;
    tick;
    tick;
    check("mid_idx3", 32'(w_data), 32'h34);
    reset = 1'b0;
    #1;
    check("mid_rst_wr", 32'(wr_uart), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_grant", 32'(grant), 0);
    data[7:0] = 8'hA5;
    req = 4'b0101;
    tick;
    reset = 1'b1;
    last_grant_cyc = cyc;
    wait_grant(0, 1);
    expect_line(0, 48'h30_3A_41_35_0D_0A, 1'b1, 1'b0, 8'h00);
    wait_grant(2, 7);
    expect_line(2, 48'h32_3A_34_34_0D_0A, 1'b1, 1'b0, 8'h00);

    // Single requester holding req is served back to back
    data[15:8] = 8'h3C;
    req = 4'b0010;
    wait_grant(1, 7);
    expect_line(1, 48'h31_3A_33_43_0D_0A, 1'b0, 1'b0, 8'h00);
    wait_grant(1, 7);
    expect_line(1, 48'h31_3A_33_43_0D_0A, 1'b1, 1'b0, 8'h00);
    tick;
    check("final_grant", 32'(grant), 0);
    check("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
